// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser followed by a stability filter.
// The debounced level changes only after the synchronised input has disagreed
// with it for STABLE_CYCLES consecutive cycles. Registered rise/fall strobes
// and a wrapping rise-event counter are provided.
// Optional feature macro: INPUT_DEBOUNCE_GLITCH_CNT_EN builds a saturating
// counter of aborted transitions. Without it, glitch_count is tied to zero.
`timescale 1ns/1ps
module input_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       clr,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic [7:0] event_count,
  output logic [7:0] glitch_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [7:0]    event_q, event_d;
  logic          abort;

  // Two-flop synchroniser; only s2_q is used past this point.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  // Stability filter: count disagreeing cycles, commit the new level on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = s2_q;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // A partial run thrown away because the input went back to the current level.
  assign abort = (cnt_q != '0) && (s2_q == level_q);

  // Rise counter: clr wins over a coincident increment.
  always_comb begin
    event_d = event_q;
    if (clr) begin
      event_d = 8'h00;
    end else if (rise_d) begin
      event_d = event_q + 8'h01;
    end
  end

  // Filter state, strobes and event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      event_q <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  // Saturating aborted-transition counter; clr wins over a coincident increment.
  always_comb begin
    glitch_d = glitch_q;
    if (clr) begin
      glitch_d = 8'h00;
    end else if (abort && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'h01;
    end
  end

  // Glitch counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= 8'h00;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_count = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign glitch_count = 8'h00;
`endif

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign event_count = event_q;

endmodule
